// File: rtl/odo_sbox_pkg.sv
// ---------------------------------------------------------------------------
// odo_sbox_pkg
// Shared constants and types for the runtime-loadable inverse 6-bit S-box.
//   SBOX_W       symbol width
//   SBOX_DEPTH   table depth (2**SBOX_W)
//   sbox_state_e table-builder state: EMPTY, LOAD, READY, ERROR
// ---------------------------------------------------------------------------
package odo_sbox_pkg;

  localparam int SBOX_W     = 6;
  localparam int SBOX_DEPTH = 2 ** SBOX_W;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    LOAD  = 2'd1,
    READY = 2'd2,
    ERROR = 2'd3
  } sbox_state_e;

endpackage

// File: rtl/odo_sbox_ram.sv
// ---------------------------------------------------------------------------
// odo_sbox_ram
// DEPTH x W single-clock RAM: synchronous write, registered read.
// The read register has a synchronous reset and holds its value when no
// read is requested, so the owner can expose it directly as a held output.
// Ports:
//   clk    clock
//   rst    synchronous active-high reset (read register only; array is not reset)
//   we     write enable; waddr/wdata written on the rising edge
//   re     read enable; rdata <= mem[raddr] on the rising edge
//   rdata  registered read data
// ---------------------------------------------------------------------------
module odo_sbox_ram
  import odo_sbox_pkg::*;
#(
  parameter int W     = SBOX_W,
  parameter int DEPTH = SBOX_DEPTH
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         we,
  input  logic [W-1:0] waddr,
  input  logic [W-1:0] wdata,
  input  logic         re,
  input  logic [W-1:0] raddr,
  output logic [W-1:0] rdata
);

  logic [W-1:0] mem [DEPTH];
  logic [W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q <= '0;
    end else if (re) begin
      rdata_q <= mem[raddr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/odo_sbox_inv_table.sv
// ---------------------------------------------------------------------------
// odo_sbox_inv_table
// Runtime-loadable inverse S-box. A forward permutation fwd[0..LAST_IDX] is
// streamed in index order; the block writes inv[fwd[i]] = i in place and
// tracks which values have been seen. A repeated value aborts the load
// (ERROR); 64 distinct values are necessarily a bijection, so the table goes
// READY right after the last transfer. In READY, registered 1-cycle inverse
// lookups are served at full rate.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   load_start               pulse: drop the current table, start a new load
//   load_valid/load_ready    forward-table entry handshake
//   load_data                fwd[i] for the implicit index i
//   tbl_ok                   table complete and bijective
//   tbl_err                  duplicate seen (held until load_start or rst)
//   lk_valid, lk_in          lookup request
//   lk_out, lk_out_valid     inv[lk_in], one cycle later
// Optional build macro ODO_SBOX_INV_FWD_EN adds a forward-table copy and the
// ports fwd_out / fwd_out_valid returning fwd[lk_in] alongside lk_out.
// ---------------------------------------------------------------------------
module odo_sbox_inv_table
  import odo_sbox_pkg::*;
#(
  parameter int W = SBOX_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_start,
  input  logic         load_valid,
  output logic         load_ready,
  input  logic [W-1:0] load_data,
  output logic         tbl_ok,
  output logic         tbl_err,
  input  logic         lk_valid,
  input  logic [W-1:0] lk_in,
  output logic [W-1:0] lk_out,
  output logic         lk_out_valid
`ifdef ODO_SBOX_INV_FWD_EN
  ,
  output logic [W-1:0] fwd_out,
  output logic         fwd_out_valid
`endif
);

  localparam int           DEPTH    = 2 ** W;
  localparam logic [W-1:0] LAST_IDX = W'(DEPTH - 1);

  sbox_state_e      state_q, state_d;
  logic [W-1:0]     idx_q, idx_d;
  logic [DEPTH-1:0] seen_q, seen_d, seen_set;
  logic             lk_out_valid_q;

  logic xfer;   // accepted forward entry (load_start takes priority)
  logic dup;    // current entry value already written this load
  logic wr_en;  // entry is new: commit it to the table(s)
  logic rd_en;  // lookup is served this cycle

  assign xfer  = (state_q == LOAD) && load_valid && !load_start;
  assign dup   = seen_q[load_data];
  assign wr_en = xfer && !dup;
  // The READY check uses the current state, so a lookup issued together
  // with load_start in READY is still served.
  assign rd_en = lk_valid && (state_q == READY);

  // One-hot decode of the value being committed.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_seen
    assign seen_set[gi] = wr_en && (load_data == W'(gi));
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    seen_d     = seen_q | seen_set;
    load_ready = 1'b0;
    tbl_ok     = 1'b0;
    tbl_err    = 1'b0;

    unique case (state_q)
      EMPTY: ;
      LOAD: begin
        load_ready = 1'b1;
        if (xfer) begin
          if (dup) begin
            state_d = ERROR;
          end else begin
            idx_d = idx_q + W'(1);
            // The final index leaves LOAD, so idx never wraps while loading.
            if (idx_q == LAST_IDX) begin
              state_d = READY;
            end
          end
        end
      end
      READY: tbl_ok  = 1'b1;
      ERROR: tbl_err = 1'b1;
      default: state_d = EMPTY;
    endcase

    if (load_start) begin
      state_d = LOAD;
      idx_d   = '0;
      seen_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= EMPTY;
      idx_q          <= '0;
      seen_q         <= '0;
      lk_out_valid_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      idx_q          <= idx_d;
      seen_q         <= seen_d;
      lk_out_valid_q <= rd_en;
    end
  end

  // Inverse table: addressed by value, stores the index.
  odo_sbox_ram #(
    .W     (W),
    .DEPTH (DEPTH)
  ) u_inv_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (wr_en),
    .waddr (load_data),
    .wdata (idx_q),
    .re    (rd_en),
    .raddr (lk_in),
    .rdata (lk_out)
  );

  assign lk_out_valid = lk_out_valid_q;

`ifdef ODO_SBOX_INV_FWD_EN
  // Forward copy: addressed by index, stores the value.
  odo_sbox_ram #(
    .W     (W),
    .DEPTH (DEPTH)
  ) u_fwd_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (wr_en),
    .waddr (idx_q),
    .wdata (load_data),
    .re    (rd_en),
    .raddr (lk_in),
    .rdata (fwd_out)
  );

  assign fwd_out_valid = lk_out_valid_q;
`endif

endmodule

// File: doc/odo_sbox_inv_table.md
Name: odo_sbox_inv_table

Overview:
- Runtime-loadable inverse 6-bit S-box for the Odo datapath.
- Accepts a forward 64-entry permutation streamed in index order and builds the inverse table in place (inv[fwd[i]] = i).
- Rejects any table that is not a bijection.
- Once the table is valid, serves registered inverse lookups. Decode/verify paths use it to undo a per-epoch forward substitution.

Parameters:
- W, 6, symbol width; table depth is 2**W.
- LAST_IDX, 2**W-1, final load index (derived; not to be overridden).

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous active-high reset.
- load_start  in  1  one-cycle pulse: discard current table and begin a new load.
- load_valid  in  1  forward-table entry present on load_data.
- load_ready  out  1  block accepts load_data this cycle.
- load_data  in  W  fwd[i] for the implicit index i = 0,1,..,LAST_IDX.
- tbl_ok  out  1  high while the table is complete and bijective.
- tbl_err  out  1  sticky duplicate-value error, cleared by load_start or rst.
- lk_valid  in  1  lookup request.
- lk_in  in  W  value to invert.
- lk_out  out  W  inv[lk_in], registered.
- lk_out_valid  out  1  lk_out is valid.

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high. Everything updates on the rising clk edge.
- Reset values: state=EMPTY; load_ready=0; tbl_ok=0; tbl_err=0; lk_out=0; lk_out_valid=0; load index=0; seen bitmap (2**W bits) all 0. Table RAM contents are not reset.
- States:
  - EMPTY: no table.
  - LOAD: accepting entries.
  - READY: table valid.
  - ERROR: duplicate detected.
- Transitions:
  - Any state, load_start=1 -> LOAD. Index=0, bitmap cleared, tbl_ok=0, tbl_err=0.
  - LOAD: load_ready=1. A transfer is load_valid && load_ready. On each transfer:
    - If seen[load_data]=1: go to ERROR, tbl_err=1, no write.
    - Otherwise: write inv[load_data]=index, set seen[load_data], increment index.
    - A transfer at index LAST_IDX goes to READY with tbl_ok=1 the next cycle. 64 distinct values imply a bijection, so no extra check pass is needed.
  - ERROR: load_ready=0. Stays in ERROR until load_start or rst.
  - READY: load_ready=0. Ignores load_valid.
- Lookup:
  - Applies only in READY. lk_valid at cycle t gives lk_out=inv[lk_in] and lk_out_valid=1 at t+1, so latency is 1.
  - Fully pipelined: one lookup per cycle, no backpressure.
  - Outside READY, lk_valid is ignored, lk_out_valid=0 and lk_out holds its value.
- Simultaneous events:
  - load_start with load_valid in the same cycle: load_start wins and the data is not consumed. The first entry is accepted on a later cycle.
  - load_start with lk_valid while in READY: the lookup is served (lk_out_valid=1 next cycle) and the state goes to LOAD.
  - rst overrides everything.
- Reset mid-load: returns to EMPTY and partial contents are abandoned.
- Index width is W bits. It never wraps in LOAD, because the LAST_IDX transfer exits the state.

Optional Feature:
- Macro: ODO_SBOX_INV_FWD_EN.
- Defined:
  - Adds a second RAM that also stores fwd[i]=load_data at each accepted load.
  - Adds ports fwd_out (W, out) and fwd_out_valid (1, out). lk_valid also returns fwd[lk_in] with the same 1-cycle timing and the same READY gating; both reset to 0.
  - Used for round-trip self-check.
- Undefined: these ports and the second RAM do not exist.

Decomposition:
- Shared package odo_sbox_pkg:
  - W constant and depth constant.
  - State enum {EMPTY, LOAD, READY, ERROR}.
- One natural sub-module: odo_sbox_ram (sync-write, registered-read 2**W x W RAM), instanced once, or twice with ODO_SBOX_INV_FWD_EN.

Test Plan:
- Reset then lk_valid with lk_in=0x05 -> lk_out_valid stays 0, tbl_ok=0, load_ready=0.
- load_start, then stream fwd = {0x14,0x09,0x37,0x1c,...} as a full permutation -> tbl_ok=1 one cycle after the 64th transfer. Then lk_in=0x14 -> lk_out=0x00, lk_in=0x37 -> lk_out=0x02, each 1 cycle later.
- Back-to-back lookups over all 64 values -> inv[fwd[i]]==i for every i, lk_out_valid high on every consecutive cycle.
- Load 0x14 at index 0 and 0x14 again at index 5 -> tbl_err=1 and state ERROR from the next cycle, load_ready=0, lookups ignored. A later load_start clears tbl_err.
- rst asserted after 30 entries -> EMPTY with all outputs at reset values. A fresh full load then succeeds.
- With ODO_SBOX_INV_FWD_EN: after a valid load, lk_in=0x02 -> lk_out=0x1a (assuming fwd[0x1a]=0x02) and fwd_out=0x37 in the same cycle.
